// File: rtl/qlvid_capture_if.sv
// Video-RAM write port of the QL screen capture block.
// The capture block drives the request, address and data; the RAM answers with wr_ack.
interface qlvid_capture_if;
    logic        wr_req;
    logic [13:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/qlvid_capture.sv
// QL screen capture: packs a raster pixel stream into mode 4 / mode 8 screen words and writes them to video RAM.
// Optional macro QLCAP_CONTINUOUS_EN re-arms after every frame instead of returning to IDLE.
module qlvid_capture #(
    parameter int FIFO_DEPTH     = 4,
    parameter int LINES          = 256,
    parameter int WORDS_PER_LINE = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic             pix_valid,
    input  logic             pix_sof,
    input  logic             pix_sol,
    input  logic             pix_g,
    input  logic             pix_r,
    input  logic             pix_b,
    qlvid_capture_if.master  wr,
    output logic             busy,
    output logic             frame_done,
    output logic             overflow
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [13:0] LAST_ADDR = {8'(LINES - 1), 6'(WORDS_PER_LINE - 1)};

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;

    state_t      state_r;
    logic        mode_r;
    logic [7:0]  line_r;
    logic [9:0]  px_r;
    logic [15:0] acc_r;
    logic        pend_valid_r;
    logic [15:0] pend_data_r;
    logic [13:0] pend_addr_r;
    logic [15:0] mem_data_r [FIFO_DEPTH];
    logic [13:0] mem_addr_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0] cnt_r;
    logic        req_r;
    logic        busy_r;
    logic        done_r;
    logic        ovf_r;

    logic        restart_s;
    logic        active_s;
    logic        take_s;
    logic        last_s;
    logic [9:0]  eff_px_s;
    logic [9:0]  px_limit_s;
    logic [7:0]  eff_line_s;
    logic        eff_mode_s;
    logic [5:0]  word_s;
    logic [15:0] acc_next_s;
    logic        pop_s;
    logic        full_s;
    logic        push_s;
    logic        drop_s;
    logic        last_word_s;
    logic [PW:0] cnt_next_s;

    // Bit contribution of one pixel at position i inside its word (mode 8 slots are two bits wide).
    function automatic logic [15:0] pix_bits(input logic m, input logic [2:0] i,
                                             input logic g, input logic r, input logic b);
        logic [15:0] w;
        w = 16'd0;
        if (m) begin
            w[4'd15 - {1'b0, i[1:0], 1'b0}] = g;
            w[4'd7  - {1'b0, i[1:0], 1'b0}] = r;
            w[4'd6  - {1'b0, i[1:0], 1'b0}] = b;
        end else begin
            w[4'd15 - {1'b0, i}] = g;
            w[4'd7  - {1'b0, i}] = r;
        end
        return w;
    endfunction

    assign pop_s       = req_r && wr.wr_ack;
    assign full_s      = (cnt_r == (PW + 1)'(FIFO_DEPTH));
    assign push_s      = pend_valid_r && (!full_s || pop_s);
    assign drop_s      = pend_valid_r && full_s && !pop_s;
    assign last_word_s = pend_valid_r && (pend_addr_r == LAST_ADDR);
    assign cnt_next_s  = cnt_r + (PW + 1)'(push_s) - (PW + 1)'(pop_s);

    // Resolve where the current pixel lands: frame/line restarts override the running position.
    always_comb begin
        restart_s  = 1'b0;
        active_s   = 1'b0;
        eff_px_s   = px_r;
        eff_line_s = line_r;
        eff_mode_s = mode_r;
        case (state_r)
            ARMED: begin
                if (pix_valid && pix_sof) begin
                    restart_s  = 1'b1;
                    active_s   = 1'b1;
                    eff_px_s   = 10'd0;
                    eff_line_s = 8'd0;
                    eff_mode_s = mode;
                end else begin
                    active_s = 1'b0;
                end
            end
            CAPTURE: begin
                if (pix_valid && !last_word_s) begin
                    active_s = 1'b1;
                    if (pix_sof) begin
                        restart_s  = 1'b1;
                        eff_px_s   = 10'd0;
                        eff_line_s = 8'd0;
                        eff_mode_s = mode;
                    end else if (pix_sol) begin
                        restart_s  = 1'b1;
                        eff_px_s   = 10'd0;
                        eff_line_s = line_r + 8'd1;
                    end else begin
                        restart_s = 1'b0;
                    end
                end else begin
                    active_s = 1'b0;
                end
            end
            default: active_s = 1'b0;
        endcase
        px_limit_s = eff_mode_s ? 10'd256 : 10'd512;
        take_s     = active_s && (eff_px_s < px_limit_s);
        word_s     = eff_mode_s ? eff_px_s[7:2] : eff_px_s[8:3];
        last_s     = eff_mode_s ? (eff_px_s[1:0] == 2'd3) : (eff_px_s[2:0] == 3'd7);
        acc_next_s = (restart_s ? 16'd0 : acc_r)
                   | pix_bits(eff_mode_s, eff_px_s[2:0], pix_g, pix_r, pix_b);
    end

    // Control FSM, packer, write FIFO and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            mode_r       <= 1'b0;
            line_r       <= 8'd0;
            px_r         <= 10'd0;
            acc_r        <= 16'd0;
            pend_valid_r <= 1'b0;
            pend_data_r  <= 16'd0;
            pend_addr_r  <= 14'd0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            cnt_r        <= '0;
            req_r        <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            ovf_r        <= 1'b0;
        end else begin
            done_r       <= 1'b0;
            pend_valid_r <= 1'b0;
            cnt_r        <= cnt_next_s;
            req_r        <= (cnt_next_s != '0);
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= pend_data_r;
                mem_addr_r[wr_ptr_r] <= pend_addr_r;
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
            if (take_s) begin
                mode_r <= eff_mode_s;
                line_r <= eff_line_s;
                px_r   <= eff_px_s + 10'd1;
                if (last_s) begin
                    pend_valid_r <= 1'b1;
                    pend_data_r  <= acc_next_s;
                    pend_addr_r  <= {eff_line_s, word_s};
                    acc_r        <= 16'd0;
                end else begin
                    acc_r <= acc_next_s;
                end
            end
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= ARMED;
                        busy_r  <= 1'b1;
                        ovf_r   <= 1'b0;
                    end
                end
                ARMED: begin
                    if (restart_s) begin
                        state_r <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Last word of the frame was pushed or dropped this cycle.
                    if (last_word_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((cnt_r == '0) && !pend_valid_r) begin
                        done_r  <= 1'b1;
`ifdef QLCAP_CONTINUOUS_EN
                        state_r <= ARMED;
                        busy_r  <= 1'b1;
`else
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign wr.wr_req   = req_r;
    assign wr.wr_addr  = req_r ? mem_addr_r[rd_ptr_r] : 14'd0;
    assign wr.wr_data  = req_r ? mem_data_r[rd_ptr_r] : 16'd0;
    assign busy        = busy_r;
    assign frame_done  = done_r;
    assign overflow    = ovf_r;
endmodule

// File: tb/tb_qlvid_capture.sv
// Directed bench for qlvid_capture with a reduced line count; writes are logged and compared to hand-built expectations.
module tb_qlvid_capture;
    localparam int LINES = 16;

    logic clk = 1'b0;
    logic reset, start, mode, pix_valid, pix_sof, pix_sol, pix_g, pix_r, pix_b;
    logic busy, frame_done, overflow;

    qlvid_capture_if wif();

    qlvid_capture #(.FIFO_DEPTH(4), .LINES(LINES), .WORDS_PER_LINE(64)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_sol(pix_sol),
        .pix_g(pix_g), .pix_r(pix_r), .pix_b(pix_b),
        .wr(wif), .busy(busy), .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [13:0] log_addr [$];
    logic [15:0] log_data [$];
    logic [13:0] exp_addr [$];
    logic [15:0] exp_data [$];

    // Record every accepted write and every frame_done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && wif.wr_req && wif.wr_ack) begin
            log_addr.push_back(wif.wr_addr);
            log_data.push_back(wif.wr_data);
        end
        if (frame_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    function automatic logic [2:0] colour(input int pat, input int l, input int p);
        case (pat)
            0: return (p % 2 == 0) ? 3'b100 : 3'b010;
            1: return 3'b111;
            default: begin
                if (l == 3 && p == 0) return 3'b100;
                if (l == 3 && p == 1) return 3'b010;
                if (l == 3 && p == 2) return 3'b001;
                if (l == 3 && p == 3) return 3'b111;
                return 3'b000;
            end
        endcase
    endfunction

    function automatic logic [15:0] word_of(input int pat, input logic [13:0] a);
        case (pat)
            0: return 16'hAA55;
            1: return 16'hAAFF;
            default: return (a == 14'h00C0) ? 16'h8227 : 16'h0000;
        endcase
    endfunction

    // Append expected writes for lines 0..nlines-1 plus words 0..xwords-1 of line nlines, skipping skip0/skip1.
    task automatic add_exp(input int pat, input int nlines, input int xwords, input int skip0, input int skip1);
        for (int l = 0; l <= nlines && l < LINES; l++) begin
            for (int w = 0; w < 64; w++) begin
                logic [13:0] a;
                a = {8'(l), 6'(w)};
                if ((l < nlines || w < xwords) && int'(a) != skip0 && int'(a) != skip1) begin
                    exp_addr.push_back(a);
                    exp_data.push_back(word_of(pat, a));
                end
            end
        end
    endtask

    task automatic compare_log(input string tag, input int base);
        int n, bad, first;
        n = log_addr.size() - base;
        bad = 0;
        first = -1;
        check({tag, " write count"}, 32'(n), 32'(exp_addr.size()));
        for (int i = 0; i < n && i < exp_addr.size(); i++) begin
            if (log_addr[base+i] !== exp_addr[i] || log_data[base+i] !== exp_data[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        if (first >= 0)
            $display("  %s first difference at write %0d: addr %h data %h, wanted addr %h data %h", tag, first,
                     log_addr[base+first], log_data[base+first], exp_addr[first], exp_data[first]);
        check({tag, " wrong writes"}, 32'(bad), 32'd0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Stream a frame; stops before (stop_line, stop_px); wr_ack low from stall_lo to stall_hi on stall_line.
    task automatic drive_frame(input logic m, input int pat, input int stop_line, input int stop_px,
                               input int stall_line, input int stall_lo, input int stall_hi);
        int ppl;
        ppl = m ? 256 : 512;
        for (int l = 0; l < LINES; l++) begin
            for (int p = 0; p < ppl; p++) begin
                if (l == stop_line && p == stop_px) begin
                    @(posedge clk); #1 pix_valid = 1'b0; pix_sof = 1'b0; pix_sol = 1'b0;
                    return;
                end
                @(posedge clk); #1;
                if (l == stall_line && p == stall_lo) wif.wr_ack = 1'b0;
                if (l == stall_line && p == stall_hi) wif.wr_ack = 1'b1;
                pix_valid = 1'b1;
                pix_sof   = (l == 0 && p == 0);
                pix_sol   = (p == 0);
                {pix_g, pix_r, pix_b} = colour(pat, l, p);
            end
        end
        @(posedge clk); #1 pix_valid = 1'b0; pix_sof = 1'b0; pix_sol = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int dbase, input int budget);
        for (int i = 0; i < budget && done_cnt == dbase; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check({tag, " frame_done pulses"}, 32'(done_cnt - dbase), 32'd1);
    endtask

    function automatic logic [15:0] logged_word(input int base, input logic [13:0] a);
        for (int i = base; i < log_addr.size(); i++)
            if (log_addr[i] == a) return log_data[i];
        return 16'hDEAD;
    endfunction

    initial begin
        int base, dbase;
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_sol = 1'b0;
        pix_g = 1'b0; pix_r = 1'b0; pix_b = 1'b0;
        wif.wr_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset wr_req", 32'(wif.wr_req), 32'd0);
        check("reset wr_addr", 32'(wif.wr_addr), 32'd0);
        check("reset wr_data", 32'(wif.wr_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // Mode 4 alternating green/red, ack always high.
        base = log_addr.size(); dbase = done_cnt;
        add_exp(0, LINES, 0, -1, -1);
        mode = 1'b0;
        pulse_start();
        @(negedge clk);
        check("m4 busy after start", 32'(busy), 32'd1);
        drive_frame(1'b0, 0, -1, -1, -1, -1, -1);
        wait_done("m4", dbase, 200);
        compare_log("m4", base);
        check("m4 overflow", 32'(overflow), 32'd0);
        check("m4 busy at end", 32'(busy), 32'd0);

        // Mode 8 colour test on line 3.
        base = log_addr.size(); dbase = done_cnt;
        add_exp(2, LINES, 0, -1, -1);
        mode = 1'b1;
        pulse_start();
        drive_frame(1'b1, 2, -1, -1, -1, -1, -1);
        wait_done("m8 colours", dbase, 200);
        check("m8 word at 0x00C0", 32'(logged_word(base, 14'h00C0)), 32'h8227);
        check("m8 word at 0x00C1", 32'(logged_word(base, 14'h00C1)), 32'h0000);
        compare_log("m8 colours", base);

        // Write port stalled 40 cycles on line 2: words 0..3 kept, word 4 dropped.
        base = log_addr.size(); dbase = done_cnt;
        add_exp(0, LINES, 0, 'h084, -1);
        mode = 1'b0;
        pulse_start();
        drive_frame(1'b0, 0, -1, -1, 2, 4, 44);
        wait_done("stall", dbase, 200);
        compare_log("stall", base);
        check("stall overflow", 32'(overflow), 32'd1);

        // Restart by pix_sof while line 10 word 4 is half filled.
        base = log_addr.size(); dbase = done_cnt;
        add_exp(0, 10, 4, -1, -1);
        add_exp(0, LINES, 0, -1, -1);
        pulse_start();
        @(negedge clk);
        check("start clears overflow", 32'(overflow), 32'd0);
        drive_frame(1'b0, 0, 10, 36, -1, -1, -1);
        drive_frame(1'b0, 0, -1, -1, -1, -1, -1);
        wait_done("sof restart", dbase, 200);
        check("sof restart write after 0x0283", 32'(log_addr[base + 644]), 32'h0000);
        compare_log("sof restart", base);

        // Reset while draining with the last two words still queued.
        base = log_addr.size(); dbase = done_cnt;
        add_exp(0, LINES, 0, (LINES-1)*64 + 62, (LINES-1)*64 + 63);
        pulse_start();
        drive_frame(1'b0, 0, -1, -1, LINES-1, 500, -1);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("drain wr_req pending", 32'(wif.wr_req), 32'd1);
        check("drain busy", 32'(busy), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("after reset wr_req", 32'(wif.wr_req), 32'd0);
        check("after reset busy", 32'(busy), 32'd0);
        wif.wr_ack = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("after reset no frame_done", 32'(done_cnt - dbase), 32'd0);
        compare_log("reset in drain", base);

        // Mode 8 all white from a fresh start after the reset.
        base = log_addr.size(); dbase = done_cnt;
        add_exp(1, LINES, 0, -1, -1);
        mode = 1'b1;
        pulse_start();
        @(negedge clk);
        check("start after reset busy", 32'(busy), 32'd1);
        drive_frame(1'b1, 1, -1, -1, -1, -1, -1);
        wait_done("m8 white", dbase, 200);
        compare_log("m8 white", base);
        check("m8 white overflow", 32'(overflow), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
